// File: rtl/dadda_mul_arbiter.sv
// Round-robin arbiter sharing one 16x16 Dadda multiplier among NUM_REQ valid/ready requesters.
// The product is registered and returned with the requester id on a single response channel.
module dadda_mul_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_product,
    output logic [ID_W-1:0]         resp_id,
    output logic                    busy,
    output logic [15:0]             op_count
);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_id;
    logic [15:0]     r_op_a;
    logic [15:0]     r_op_b;
    logic            r_resp_valid;
    logic [31:0]     r_resp_product;
    logic [ID_W-1:0] r_resp_id;
    logic [15:0]     r_op_count;

    logic            w_win_found;
    logic [ID_W-1:0] w_win_id;
    logic [15:0]     w_sel_a;
    logic [15:0]     w_sel_b;
    logic            w_accept;
    logic [31:0]     w_product;

    // Target row heights of the Dadda reduction sequence down to two rows.
    function automatic int stage_height(input int s);
        case (s)
            0:       return 13;
            1:       return 9;
            2:       return 6;
            3:       return 4;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    // Each stage compresses only enough row triples (in parallel) to reach the next height.
    function automatic logic [31:0] dadda_mul16(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] rows [16];
        logic [31:0] nr   [16];
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        int          n;
        int          tgt;
        int          c;
        for (int i = 0; i < 16; i++) begin
            rows[i] = b[i] ? (32'(a) << i) : 32'd0;
        end
        n = 16;
        for (int s = 0; s < 6; s++) begin
            tgt = stage_height(s);
            c   = n - tgt;
            for (int j = 0; j < 16; j++) begin
                nr[j] = 32'd0;
            end
            for (int j = 0; j < 5; j++) begin
                if (j < c) begin
                    x         = rows[3*j];
                    y         = rows[3*j+1];
                    z         = rows[3*j+2];
                    nr[2*j]   = x ^ y ^ z;
                    nr[2*j+1] = ((x & y) | (x & z) | (y & z)) << 1;
                end
            end
            for (int j = 0; j < 16; j++) begin
                if (j >= 3*c && j < n) begin
                    nr[j-c] = rows[j];
                end
            end
            rows = nr;
            n    = tgt;
        end
        return rows[0] + rows[1];
    endfunction

    assign w_product = dadda_mul16(r_op_a, r_op_b);

    // Search starts just past the last grantee so it gets lowest priority.
    always_comb begin
        logic [ID_W-1:0] idx;
        w_win_found = 1'b0;
        w_win_id    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((32'(r_ptr) + k) % NUM_REQ);
            if (!w_win_found && req_valid[idx]) begin
                w_win_found = 1'b1;
                w_win_id    = idx;
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_win_id == ID_W'(i)) begin
                w_sel_a = req_a[16*i +: 16];
                w_sel_b = req_b[16*i +: 16];
            end
        end
    end

    assign w_accept = (r_state == StIdle) && w_win_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_next = StMul;
            StMul:   w_state_next = StDone;
            StDone:  if (r_resp_valid && resp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (r_state != StIdle);
        if (w_accept) begin
            req_ready[w_win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr          <= ID_W'(NUM_REQ - 1);
            r_id           <= '0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_product <= '0;
            r_resp_id      <= '0;
            r_op_count     <= '0;
        end else begin
            if (w_accept) begin
                r_op_a <= w_sel_a;
                r_op_b <= w_sel_b;
                r_id   <= w_win_id;
                r_ptr  <= w_win_id;
            end
            if (r_state == StMul) begin
                r_resp_product <= w_product;
                r_resp_id      <= r_id;
                r_resp_valid   <= 1'b1;
            end
            if (r_state == StDone && r_resp_valid && resp_ready) begin
                r_resp_valid <= 1'b0;
                r_op_count   <= r_op_count + 16'd1;
            end
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_product = r_resp_product;
    assign resp_id      = r_resp_id;
    assign op_count     = r_op_count;

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Scoreboard bench for dadda_mul_arbiter: directed vectors push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_dadda_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_product;
    logic [ID_W-1:0]       resp_id;
    logic                  busy;
    logic [15:0]           op_count;

    dadda_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_product (resp_product),
        .resp_id      (resp_id),
        .busy         (busy),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     prod;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks     = 0;
    int   failures   = 0;
    int   hs_count   = 0;
    bit   auto_push  = 1'b0;
    int   wait_grants [NUM_REQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] prod);
        exp_t e;
        e.id   = ID_W'(id);
        e.prod = prod;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected: got id %0d product 0x%0h, expected no response",
                         resp_id, resp_product);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_id", 32'(resp_id), 32'(mon_e.id));
                check("resp_product", resp_product, mon_e.prod);
            end
            hs_count++;
        end
    end

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_valid[i]      = 1'b1;
    endtask

    // One clock: sample transfers at negedge, retire accepted requests just after posedge.
    task automatic step();
        logic [NUM_REQ-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        if (auto_push) begin
            check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) begin
                    push(i, 32'(req_a[16*i +: 16]) * 32'(req_b[16*i +: 16]));
                    checks++;
                    if (wait_grants[i] > NUM_REQ - 1) begin
                        failures++;
                        $display("FAIL starve_wait: requester %0d waited %0d grants, max %0d",
                                 i, wait_grants[i], NUM_REQ - 1);
                    end
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (j != i && req_valid[j]) wait_grants[j]++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic run_idle(input int budget, input string name);
        int n = 0;
        while ((req_valid != 0 || busy || resp_valid) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, budget);
        end
    endtask

    task automatic wait_resp(input int budget, input string name);
        int n = 0;
        while (!resp_valid && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(resp_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        hs_count = 0;
        rst_n    = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        int cyc;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_product", resp_product, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester 0: 25*8
        resp_ready = 1'b1;
        set_req(0, 16'd25, 16'd8);
        push(0, 32'd200);
        #1;
        check("t1_req_ready", 32'(req_ready), 32'h1);
        step();
        check("t1_busy_mul", 32'(busy), 32'd1);
        check("t1_ready_mul", 32'(req_ready), 32'h0);
        check("t1_valid_mul", 32'(resp_valid), 32'd0);
        step();
        check("t1_resp_valid", 32'(resp_valid), 32'd1);
        step();
        check("t1_op_count", 32'(op_count), 32'd1);
        check("t1_valid_clr", 32'(resp_valid), 32'd0);

        // All four valid after reset: served 0,1,2,3
        do_reset();
        resp_ready = 1'b1;
        set_req(0, 16'd1642, 16'd166);
        set_req(1, 16'd15, 16'd170);
        set_req(2, 16'd187, 16'd82);
        set_req(3, 16'd0, 16'd6587);
        push(0, 32'd272572);
        push(1, 32'd2550);
        push(2, 32'd15334);
        push(3, 32'd0);
        run_idle(40, "t2");
        check("t2_op_count", 32'(op_count), 32'd4);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // Max operands on requester 3
        set_req(3, 16'hFFFF, 16'hFFFF);
        push(3, 32'hFFFE0001);
        run_idle(20, "t3");
        check("t3_op_count", 32'(op_count), 32'd5);

        // Back-pressure with requester 1 re-requesting during DONE
        resp_ready = 1'b0;
        set_req(1, 16'd300, 16'd7);
        push(1, 32'd2100);
        wait_resp(10, "t4_resp_valid");
        set_req(1, 16'd1000, 16'd1000);
        for (int k = 0; k < 10; k++) begin
            step();
            check("t4_hold_valid", 32'(resp_valid), 32'd1);
            check("t4_hold_product", resp_product, 32'd2100);
            check("t4_hold_id", 32'(resp_id), 32'd1);
            check("t4_hold_ready", 32'(req_ready), 32'h0);
        end
        check("t4_hold_count", 32'(op_count), 32'd5);
        resp_ready = 1'b1;
        push(1, 32'd1000000);
        step();
        check("t4_one_hs", 32'(op_count), 32'd6);
        check("t4_valid_clr", 32'(resp_valid), 32'd0);
        check("t4_regrant", 32'(req_ready), 32'h2);
        run_idle(20, "t4");
        check("t4_op_count", 32'(op_count), 32'd7);

        // Async reset while in DONE
        resp_ready = 1'b0;
        set_req(2, 16'd5, 16'd5);
        wait_resp(10, "t5_resp_valid");
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(resp_valid), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_count", 32'(op_count), 32'd0);
        check("t5_async_product", resp_product, 32'd0);
        check("t5_async_id", 32'(resp_id), 32'd0);
        exp_q.delete();
        hs_count = 0;
        @(posedge clk);
        #1;
        set_req(2, 16'd3, 16'd4);
        set_req(3, 16'd5, 16'd6);
        rst_n = 1'b1;
        #1;
        check("t5_first_grant", 32'(req_ready), 32'h4);
        resp_ready = 1'b1;
        push(2, 32'd12);
        push(3, 32'd30);
        run_idle(40, "t5");
        check("t5_op_count", 32'(op_count), 32'd2);

        // Random stream with random back-pressure
        auto_push = 1'b1;
        issued    = 0;
        cyc       = 0;
        while (issued < 300 && cyc < 6000) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && issued < 300 && $urandom_range(0, 1) == 1) begin
                    set_req(i, 16'($urandom), 16'($urandom));
                    wait_grants[i] = 0;
                    issued++;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
        end
        check("t6_issued", 32'(issued), 32'd300);
        resp_ready = 1'b1;
        run_idle(200, "t6");
        auto_push = 1'b0;
        check("t6_op_count", 32'(op_count), 32'(hs_count[15:0]));
        check("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
